// File: rtl/transpose_unbuffer.sv
// Column-in / row-out tile reassembly with ping-pong banks (inverse of transpose_buffer).
// Define TRANSPOSE_UNBUF_OUT_REG_EN to add a registered one-entry output stage.
module transpose_unbuffer #(
    parameter int PIX_W    = 16,
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 4,
    localparam int RIDX_W  = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      col_valid,
    input  logic [NUM_ROWS*PIX_W-1:0] col_data,
    output logic                      col_ready,
    output logic                      row_valid,
    output logic [NUM_COLS*PIX_W-1:0] row_data,
    input  logic                      row_ready,
    output logic [RIDX_W-1:0]         row_index,
    output logic [1:0]                bank_full
);

    localparam int CIDX_W = $clog2(NUM_COLS);

    logic [PIX_W-1:0] mem [2][NUM_ROWS][NUM_COLS];

    logic                  wr_bank;
    logic                  rd_bank;
    logic [CIDX_W-1:0]     wr_col;
    logic [RIDX_W-1:0]     rd_row;
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  col_fire;
    logic                  pop;
    logic                  wr_last;
    logic                  rd_last;
    logic [NUM_COLS*PIX_W-1:0] rd_vec;

    assign col_ready = ~full_q[wr_bank];
    assign col_fire  = col_valid & col_ready;
    assign wr_last   = (wr_col == CIDX_W'(NUM_COLS - 1));
    assign rd_last   = (rd_row == RIDX_W'(NUM_ROWS - 1));
    assign bank_full = full_q;

    // A completing write and a completing read always name different banks,
    // so both flag updates can be applied independently.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        full_d = full_q;
        if (col_fire && wr_last)
            full_d[wr_bank] = 1'b1;
        if (pop && rd_last)
            full_d[rd_bank] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_col  <= '0;
            rd_bank <= 1'b0;
            rd_row  <= '0;
            full_q  <= '0;
        end else if (flush) begin
            wr_bank <= 1'b0;
            wr_col  <= '0;
            rd_bank <= 1'b0;
            rd_row  <= '0;
            full_q  <= '0;
        end else begin
            if (col_fire) begin
                if (wr_last) begin
                    wr_col  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_col <= wr_col + CIDX_W'(1);
                end
            end
            if (pop) begin
                if (rd_last) begin
                    rd_row  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_row <= rd_row + RIDX_W'(1);
                end
            end
            full_q <= full_d;
        end
    end

    // NOTE: pixel storage has no reset; full flags guard every read of stale contents.
    always_ff @(posedge clk) begin
        if (col_fire && !flush) begin
            for (int r = 0; r < NUM_ROWS; r++)
                mem[wr_bank][r][wr_col] <= col_data[r*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int c = 0; c < NUM_COLS; c++)
            rd_vec[c*PIX_W +: PIX_W] = mem[rd_bank][rd_row][c];
    end

`ifdef TRANSPOSE_UNBUF_OUT_REG_EN
    // Stage refills whenever it is empty or its row leaves this cycle.
    assign pop = full_q[rd_bank] & (~row_valid | row_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= 1'b0;
            row_data  <= '0;
            row_index <= '0;
        end else if (flush) begin
            row_valid <= 1'b0;
            row_data  <= '0;
            row_index <= '0;
        end else if (pop) begin
            row_valid <= 1'b1;
            row_data  <= rd_vec;
            row_index <= rd_row;
        end else if (row_ready) begin
            row_valid <= 1'b0;
            row_data  <= '0;
            row_index <= '0;
        end
    end
`else
    assign row_valid = full_q[rd_bank];
    assign row_data  = row_valid ? rd_vec : '0;
    assign row_index = rd_row;
    assign pop       = row_valid & row_ready;
`endif

endmodule
